// File: rtl/inv_lut_seq.sv
// inv_lut_seq: inverse byte-substitution of a 128-bit vector, LANES bytes per cycle
// Ports: tbl_we/tbl_fwd_in/tbl_fwd_out/tbl_clr load or clear the inverse table (IDLE only),
// dup_err flags a rewrite of a valid index; vec_in/in_valid/in_ready accept a vector,
// vec_out/out_miss/out_valid/out_ready return it; busy is high outside IDLE.
module inv_lut_seq #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tbl_we,
    input  logic [7:0]   tbl_fwd_in,
    input  logic [7:0]   tbl_fwd_out,
    input  logic         tbl_clr,
    output logic         dup_err,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] vec_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] vec_out,
    output logic [15:0]  out_miss,
    output logic         busy
);
    localparam int CHUNKS = 16 / LANES;
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
    logic [1:0]   state;
    logic [3:0]   chunk;
    logic [127:0] work;
    logic [255:0] valid;
    logic [7:0]   inv [256];
    assign in_ready = (state == IDLE) && !tbl_we && !tbl_clr;
    assign busy     = state != IDLE;
    // Data array is left unreset; the valid bitmap alone decides hits.
    always_ff @(posedge clk)
        if (state == IDLE && tbl_we && !tbl_clr) inv[tbl_fwd_out] <= tbl_fwd_in;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            chunk     <= '0;
            work      <= '0;
            valid     <= '0;
            vec_out   <= '0;
            out_miss  <= '0;
            out_valid <= 1'b0;
            dup_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (tbl_clr) begin
                        valid   <= '0;
                        dup_err <= 1'b0;
                    end else if (tbl_we) begin
                        valid[tbl_fwd_out] <= 1'b1;
                        if (valid[tbl_fwd_out]) dup_err <= 1'b1;
                    end else if (in_valid) begin
                        work     <= vec_in;
                        chunk    <= '0;
                        out_miss <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    for (int j = 0; j < LANES; j++) begin
                        vec_out[(int'(chunk) * LANES + j) * 8 +: 8] <=
                            valid[work[(int'(chunk) * LANES + j) * 8 +: 8]] ?
                            inv[work[(int'(chunk) * LANES + j) * 8 +: 8]] : 8'h00;
                        out_miss[int'(chunk) * LANES + j] <=
                            !valid[work[(int'(chunk) * LANES + j) * 8 +: 8]];
                    end
                    chunk <= chunk + 4'd1;
                    if (chunk == 4'(CHUNKS - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
